// File: rtl/tx_serializer_pkg.sv
// Shared types and helpers for the multi-channel TX serializer: FSM encoding,
// channel-index width and channel-slice addressing of the packed TDATA bus.
package tx_serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

    // LSB of channel ch inside a packed bus of width-bit slices.
    function automatic int slice_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant and
// wraps explicitly mod CH_NUM, so a non-power-of-two channel count never grants an unused index.
module rr_arbiter
    import tx_serializer_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int CH_W   = ch_width(CH_NUM)
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [CH_W-1:0]   last_ptr,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_vld
);

    logic [CH_W-1:0] cand_s;
    logic            hit_s;
    logic            found_s;
    logic [CH_W-1:0] grant_idx_s;

    // Walk candidates in priority order and latch the first requesting one.
    always_comb begin
        cand_s      = '0;
        hit_s       = 1'b0;
        found_s     = 1'b0;
        grant_idx_s = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            cand_s      = CH_W'((int'(last_ptr) + k) % CH_NUM);
            hit_s       = req[cand_s] & ~found_s;
            found_s     = found_s | hit_s;
            grant_idx_s = hit_s ? cand_s : grant_idx_s;
        end
    end

    assign grant_idx = grant_idx_s;
    assign grant_vld = found_s;

endmodule

// File: rtl/multi_channel_serializer.sv
// Merges CH_NUM first-word-fall-through channel FIFOs into one TX word stream,
// one whole frame at a time, with downstream pause and a runaway-frame guard.
module multi_channel_serializer
    import tx_serializer_pkg::*;
#(
    parameter int S_AXIS_TDATA_WIDTH = 64,
    parameter int TX_RX_M_AXIS_WIDTH = 64,
    parameter int CH_NUM             = 4,
    parameter int MAX_FRAME_WORDS    = 256,
    parameter int ID_INSERT          = 0,
    parameter int ID_LSB             = 56
) (
    input  logic                                   TX_ACLK,
    input  logic                                   TX_ARESET,
    input  logic [CH_NUM*S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [CH_NUM-1:0]                      S_AXIS_TUSER,
    input  logic [CH_NUM-1:0]                      S_AXIS_TLAST,
    input  logic [CH_NUM-1:0]                      DATA_EMPTY,
    input  logic                                   PLS_WAIT,
    output logic [TX_RX_M_AXIS_WIDTH-1:0]          SERIALIZED_DATA,
    output logic                                   WR_EN,
    output logic [CH_NUM-1:0]                      RE_EN,
    output logic [ch_width(CH_NUM)-1:0]            CUR_CH,
    output logic                                   FRAME_DONE,
    output logic                                   FRAME_ERR
);

    localparam int S_W   = S_AXIS_TDATA_WIDTH;
    localparam int M_W   = TX_RX_M_AXIS_WIDTH;
    localparam int CH_W  = ch_width(CH_NUM);
    localparam int CNT_W = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_FRAME_WORDS - 1);
    localparam logic [CH_W-1:0]  LAST_INIT = CH_W'(CH_NUM - 1);

    state_e             state_r;
    state_e             state_next_s;
    logic [CH_W-1:0]    sel_r;
    logic [CH_W-1:0]    last_r;
    logic [CH_W-1:0]    cur_ch_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [M_W-1:0]     data_r;
    logic               wr_en_r;
    logic               frame_done_r;
    logic               frame_err_r;

    logic [CH_W-1:0]    grant_idx_s;
    logic               grant_vld_s;
    logic               pop_s;
    logic               cnt_max_s;
    logic               frame_end_s;
    logic               forced_s;
    logic               stamp_s;
    logic [CH_NUM-1:0]  re_en_s;
    logic [M_W-1:0]     raw_word_s;
    logic [M_W-1:0]     word_s;

    rr_arbiter #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .req       (~DATA_EMPTY),
        .last_ptr  (last_r),
        .grant_idx (grant_idx_s),
        .grant_vld (grant_vld_s)
    );

    // FSM state register.
    always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
        if (TX_ARESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: leave IDLE on any grant, leave STREAM after the frame's last pop.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) state_next_s = ST_STREAM;
                else             state_next_s = ST_IDLE;
            end
            ST_STREAM: begin
                if (pop_s && frame_end_s) state_next_s = ST_IDLE;
                else                      state_next_s = ST_STREAM;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: pop strobe for the granted channel; reset kills it asynchronously.
    always_comb begin
        re_en_s     = '0;
        cnt_max_s   = (cnt_r == CNT_LAST);
        frame_end_s = S_AXIS_TLAST[sel_r] | cnt_max_s;
        forced_s    = cnt_max_s & ~S_AXIS_TLAST[sel_r];
        pop_s       = (state_r == ST_STREAM) & ~DATA_EMPTY[sel_r] & ~PLS_WAIT & ~TX_ARESET;
        if (pop_s) re_en_s[sel_r] = 1'b1;
        else       re_en_s        = '0;
    end

    // Head word of the granted channel, zero-extended, with optional channel-ID stamp on headers.
    always_comb begin
        raw_word_s = M_W'(S_AXIS_TDATA[slice_lsb(int'(sel_r), S_W) +: S_W]);
        stamp_s    = (ID_INSERT != 0) && S_AXIS_TUSER[sel_r];
        word_s     = raw_word_s;
        if (stamp_s) word_s[ID_LSB +: CH_W] = sel_r;
        else         word_s = raw_word_s;
    end

    // Grant bookkeeping, frame word counter and registered output stage.
    always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
        if (TX_ARESET) begin
            sel_r        <= '0;
            last_r       <= LAST_INIT;
            cur_ch_r     <= '0;
            cnt_r        <= '0;
            data_r       <= '0;
            wr_en_r      <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            wr_en_r      <= pop_s;
            frame_done_r <= pop_s & frame_end_s;
            frame_err_r  <= pop_s & forced_s;
            if (pop_s) begin
                data_r <= word_s;
                cnt_r  <= frame_end_s ? '0 : cnt_r + 1'b1;
            end else begin
                data_r <= data_r;
                cnt_r  <= cnt_r;
            end
            if ((state_r == ST_IDLE) && grant_vld_s) begin
                sel_r    <= grant_idx_s;
                last_r   <= grant_idx_s;
                cur_ch_r <= grant_idx_s;
            end else begin
                sel_r    <= sel_r;
                last_r   <= last_r;
                cur_ch_r <= cur_ch_r;
            end
        end
    end

    assign RE_EN           = re_en_s;
    assign SERIALIZED_DATA = data_r;
    assign WR_EN           = wr_en_r;
    assign CUR_CH          = cur_ch_r;
    assign FRAME_DONE      = frame_done_r;
    assign FRAME_ERR       = frame_err_r;

endmodule

// File: tb/tb_multi_channel_serializer.sv
// Directed bench for multi_channel_serializer (4 channels, 8-word frame guard, ID stamping at bit 56).
module tb_multi_channel_serializer;

    logic         TX_ACLK;
    logic         TX_ARESET;
    logic [255:0] S_AXIS_TDATA;
    logic [3:0]   S_AXIS_TUSER;
    logic [3:0]   S_AXIS_TLAST;
    logic [3:0]   DATA_EMPTY;
    logic         PLS_WAIT;
    logic [63:0]  SERIALIZED_DATA;
    logic         WR_EN;
    logic [3:0]   RE_EN;
    logic [1:0]   CUR_CH;
    logic         FRAME_DONE;
    logic         FRAME_ERR;

    multi_channel_serializer #(
        .S_AXIS_TDATA_WIDTH (64),
        .TX_RX_M_AXIS_WIDTH (64),
        .CH_NUM             (4),
        .MAX_FRAME_WORDS    (8),
        .ID_INSERT          (1),
        .ID_LSB             (56)
    ) dut (
        .TX_ACLK         (TX_ACLK),
        .TX_ARESET       (TX_ARESET),
        .S_AXIS_TDATA    (S_AXIS_TDATA),
        .S_AXIS_TUSER    (S_AXIS_TUSER),
        .S_AXIS_TLAST    (S_AXIS_TLAST),
        .DATA_EMPTY      (DATA_EMPTY),
        .PLS_WAIT        (PLS_WAIT),
        .SERIALIZED_DATA (SERIALIZED_DATA),
        .WR_EN           (WR_EN),
        .RE_EN           (RE_EN),
        .CUR_CH          (CUR_CH),
        .FRAME_DONE      (FRAME_DONE),
        .FRAME_ERR       (FRAME_ERR)
    );

    initial TX_ACLK = 1'b0;
    always #5 TX_ACLK = ~TX_ACLK;

    // Channel FIFO models: {tuser, tlast, data}, 16 entries each.
    logic [65:0] mem [4][16];
    int wr_ptr [4] = '{0, 0, 0, 0};
    int rd_ptr [4] = '{0, 0, 0, 0};

    for (genvar c = 0; c < 4; c++) begin : g_ch
        assign DATA_EMPTY[c]            = (wr_ptr[c] == rd_ptr[c]);
        assign S_AXIS_TDATA[c*64 +: 64] = mem[c][rd_ptr[c][3:0]][63:0];
        assign S_AXIS_TLAST[c]          = mem[c][rd_ptr[c][3:0]][64];
        assign S_AXIS_TUSER[c]          = mem[c][rd_ptr[c][3:0]][65];
    end

    always @(posedge TX_ACLK) begin
        for (int c = 0; c < 4; c++) begin
            if (RE_EN[c]) rd_ptr[c] <= rd_ptr[c] + 1;
        end
    end

    typedef struct {
        logic [63:0] d;
        logic        done;
        logic        err;
        logic [1:0]  ch;
        int          cyc;
    } out_t;

    out_t out_q[$];
    int   pop_ch_q[$];
    int   pop_cyc_q[$];
    int   cyc = 0;

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        if ($onehot(v)) begin
            for (int i = 0; i < 4; i++) if (v[i]) r = i;
        end
        return r;
    endfunction

    // Monitor: record pops and emitted words with the edge at which they were seen.
    always @(posedge TX_ACLK) begin
        cyc <= cyc + 1;
        if (!TX_ARESET) begin
            if (RE_EN != 4'b0000) begin
                pop_ch_q.push_back(onehot_idx(RE_EN));
                pop_cyc_q.push_back(cyc);
            end
            if (WR_EN) out_q.push_back('{SERIALIZED_DATA, FRAME_DONE, FRAME_ERR, CUR_CH, cyc});
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic u, input logic l, input logic [63:0] d);
        mem[ch][wr_ptr[ch][3:0]] = {u, l, d};
        wr_ptr[ch] = wr_ptr[ch] + 1;
    endtask

    task automatic wait_outs(input int n, input string tag);
        int k;
        k = 0;
        while (out_q.size() < n && k < 300) begin
            @(negedge TX_ACLK);
            k++;
        end
        chk({tag, "_timeout"}, 64'(out_q.size() >= n), 64'd1);
    endtask

    task automatic wait_pops(input int n, input string tag);
        int k;
        k = 0;
        while (pop_ch_q.size() < n && k < 300) begin
            @(negedge TX_ACLK);
            k++;
        end
        chk({tag, "_pops"}, 64'(pop_ch_q.size()), 64'(n));
    endtask

    task automatic clear_q();
        out_q.delete();
        pop_ch_q.delete();
        pop_cyc_q.delete();
    endtask

    // Compares one captured frame list against expected words/flags and pop spacing.
    task automatic chk_stream(input string tag, input int n, input logic [63:0] exp_d [],
                              input logic exp_done [], input logic exp_err [],
                              input int exp_ch [], input int exp_gap []);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, out_q[i].d, exp_d[i]);
            chk({tag, "_done"}, 64'(out_q[i].done), 64'(exp_done[i]));
            chk({tag, "_err"},  64'(out_q[i].err),  64'(exp_err[i]));
            chk({tag, "_cur_ch"}, 64'(out_q[i].ch), 64'(exp_ch[i]));
            chk({tag, "_pop_ch"}, 64'(pop_ch_q[i]), 64'(exp_ch[i]));
            chk({tag, "_latency"}, 64'(out_q[i].cyc - pop_cyc_q[i]), 64'd1);
            if (i > 0) chk({tag, "_gap"}, 64'(pop_cyc_q[i] - pop_cyc_q[i-1]), 64'(exp_gap[i]));
        end
    endtask

    function automatic logic [63:0] mkd(input int c, input int f, input int w);
        return 64'h005A_0000_0000_0000 | 64'(c * 256 + f * 16 + w);
    endfunction

    logic [63:0] ed [];
    logic        edn [];
    logic        eer [];
    int          ech [];
    int          egp [];

    initial begin
        TX_ARESET = 1'b1;
        PLS_WAIT  = 1'b0;
        repeat (3) @(negedge TX_ACLK);
        chk("rst_wr_en", 64'(WR_EN), 64'd0);
        chk("rst_re_en", 64'(RE_EN), 64'd0);
        chk("rst_cur_ch", 64'(CUR_CH), 64'd0);
        chk("rst_data", SERIALIZED_DATA, 64'd0);
        chk("rst_done", 64'(FRAME_DONE), 64'd0);
        chk("rst_err", 64'(FRAME_ERR), 64'd0);
        TX_ARESET = 1'b0;
        @(negedge TX_ACLK);

        // All four channels with 2-word frames, ch0 holding two: served 0,1,2,3,0.
        for (int c = 0; c < 4; c++) begin
            push(c, 1'b1, 1'b0, mkd(c, 0, 0));
            push(c, 1'b0, 1'b1, mkd(c, 0, 1));
        end
        push(0, 1'b1, 1'b0, mkd(0, 1, 0));
        push(0, 1'b0, 1'b1, mkd(0, 1, 1));
        wait_outs(10, "rr");
        ed = new[10]; edn = new[10]; eer = new[10]; ech = new[10]; egp = new[10];
        for (int i = 0; i < 10; i++) begin
            ech[i] = (i < 8) ? i / 2 : 0;
            ed[i]  = mkd(ech[i], (i < 8) ? 0 : 1, i % 2);
            if (i % 2 == 0) ed[i] = ed[i] | (64'(ech[i]) << 56);
            edn[i] = (i % 2 == 1);
            eer[i] = 1'b0;
            egp[i] = (i % 2 == 0) ? 2 : 1;
        end
        chk_stream("rr", 10, ed, edn, eer, ech, egp);
        clear_q();

        // ch0 3-word frame; header bits [57:56]=01 get stamped with 00.
        push(0, 1'b1, 1'b0, 64'h1122_3344_5566_7788);
        push(0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);
        push(0, 1'b0, 1'b1, 64'hFEDC_BA98_7654_3210);
        wait_outs(3, "ch0");
        ed  = '{64'h1022_3344_5566_7788, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        edn = '{1'b0, 1'b0, 1'b1};
        eer = '{1'b0, 1'b0, 1'b0};
        ech = '{0, 0, 0};
        egp = '{0, 1, 1};
        chk_stream("ch0", 3, ed, edn, eer, ech, egp);
        clear_q();

        // ch2 6-word frame paused for 5 cycles after its second pop.
        for (int w = 0; w < 6; w++) push(2, w == 0, w == 5, 64'h2000_0000_0000_0000 + 64'(w));
        wait_pops(2, "pls_pre");
        PLS_WAIT = 1'b1;
        for (int p = 0; p < 5; p++) begin
            #1;
            chk("pls_re_en", 64'(RE_EN), 64'd0);
            chk("pls_wr_en", 64'(WR_EN), 64'(p == 0));
            @(negedge TX_ACLK);
        end
        PLS_WAIT = 1'b0;
        chk("pls_held_pops", 64'(pop_ch_q.size()), 64'd2);
        wait_outs(6, "pls");
        ed = new[6]; edn = new[6]; eer = new[6]; ech = new[6]; egp = new[6];
        for (int i = 0; i < 6; i++) begin
            ed[i]  = 64'h2000_0000_0000_0000 + 64'(i);
            edn[i] = (i == 5);
            eer[i] = 1'b0;
            ech[i] = 2;
            egp[i] = (i == 2) ? 6 : 1;
        end
        ed[0] = 64'h2200_0000_0000_0000;
        chk_stream("pls", 6, ed, edn, eer, ech, egp);
        repeat (3) @(negedge TX_ACLK);
        chk("pls_no_dup", 64'(out_q.size()), 64'd6);
        clear_q();

        // ch1 10-word frame with TLAST only on word 10: forced end after word 8.
        for (int w = 0; w < 10; w++) push(1, w == 0, w == 9, 64'h4000_0000_0000_0000 + 64'(w));
        wait_outs(10, "runaway");
        ed = new[10]; edn = new[10]; eer = new[10]; ech = new[10]; egp = new[10];
        for (int i = 0; i < 10; i++) begin
            ed[i]  = 64'h4000_0000_0000_0000 + 64'(i);
            edn[i] = (i == 7) || (i == 9);
            eer[i] = (i == 7);
            ech[i] = 1;
            egp[i] = (i == 8) ? 2 : 1;
        end
        ed[0] = 64'h4100_0000_0000_0000;
        chk_stream("runaway", 10, ed, edn, eer, ech, egp);
        clear_q();

        // Single-word frame on ch2.
        push(2, 1'b1, 1'b1, 64'h0000_0000_0000_00AA);
        wait_outs(1, "single");
        chk("single_data", out_q[0].d, 64'h0200_0000_0000_00AA);
        chk("single_done", 64'(out_q[0].done), 64'd1);
        chk("single_err", 64'(out_q[0].err), 64'd0);
        repeat (3) @(negedge TX_ACLK);
        chk("single_count", 64'(out_q.size()), 64'd1);
        clear_q();

        // ch3 frame of exactly 8 words ending with TLAST: ID stamp on header only, no error.
        push(3, 1'b1, 1'b0, 64'h0000_0000_DEAD_BEEF);
        push(3, 1'b0, 1'b0, 64'hFF00_0000_0000_0001);
        for (int w = 2; w < 8; w++) push(3, 1'b0, w == 7, 64'h3000_0000_0000_0000 + 64'(w));
        wait_outs(8, "id");
        ed = new[8]; edn = new[8]; eer = new[8]; ech = new[8]; egp = new[8];
        for (int i = 0; i < 8; i++) begin
            ed[i]  = 64'h3000_0000_0000_0000 + 64'(i);
            edn[i] = (i == 7);
            eer[i] = 1'b0;
            ech[i] = 3;
            egp[i] = 1;
        end
        ed[0] = 64'h0300_0000_DEAD_BEEF;
        ed[1] = 64'hFF00_0000_0000_0001;
        chk_stream("id", 8, ed, edn, eer, ech, egp);
        clear_q();

        // Reset in the middle of a ch1 frame; ch0 must win first afterwards.
        for (int w = 0; w < 5; w++) push(1, w == 0, w == 4, 64'h5000_0000_0000_0000 + 64'(w));
        wait_pops(2, "mid_rst");
        TX_ARESET = 1'b1;
        #1;
        chk("mid_rst_wr_en", 64'(WR_EN), 64'd0);
        chk("mid_rst_re_en", 64'(RE_EN), 64'd0);
        chk("mid_rst_cur_ch", 64'(CUR_CH), 64'd0);
        chk("mid_rst_done", 64'(FRAME_DONE), 64'd0);
        clear_q();
        push(0, 1'b1, 1'b1, 64'h0300_0000_0000_0077);
        repeat (2) @(negedge TX_ACLK);
        TX_ARESET = 1'b0;
        wait_outs(1, "post_rst");
        chk("post_rst_pop_ch", 64'(pop_ch_q[0]), 64'd0);
        chk("post_rst_data", out_q[0].d, 64'h0000_0000_0000_0077);
        chk("post_rst_cur_ch", 64'(out_q[0].ch), 64'd0);
        chk("post_rst_done", 64'(out_q[0].done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
